id_ex_hazard_stage: RTL
=======================

ID_EX_HAZARD_STAGE -- requirements
Module: id_ex_hazard_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning operand/immediate datapath width.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; every port is listed below as name, direction, width, meaning.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 flush  input  1  taken branch/jump; squash the instruction currently in ID.
REQ-007 IF_ID_Rs, IF_ID_Rt, IF_ID_Rd  input  5 each  register fields of the instruction in ID.
REQ-008 ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst  input  1 each  decoded control for the instruction in ID.
REQ-009 ID_ALUOp  input  3  decoded ALU operation.
REQ-010 ID_RsData, ID_RtData, ID_Imm  input  DATA_W each  register-file reads and sign-extended immediate.
REQ-011 ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  output  5 each  registered register fields; ID_EX_Rs and ID_EX_Rt feed the forwarding unit.
REQ-012 ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_RegDst  output  1 each  registered control.
REQ-013 ID_EX_ALUOp  output  3  registered ALU operation.
REQ-014 ID_EX_RsData, ID_EX_RtData, ID_EX_Imm  output  DATA_W each  registered data.
REQ-015 stall  output  1  load-use hazard; upstream holds PC and IF/ID while high.
REQ-016 stall_count  output  CNT_W  number of stall cycles since reset.

Function
REQ-017 hazard SHALL be combinational: ID_EX_MemRead & (ID_EX_Rt != 0) & ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt)).
REQ-018 stall SHALL equal hazard & ~flush; a flush overrides a stall in the same cycle.
REQ-019 Each rising edge with rst_n high and (hazard | flush) SHALL load a bubble: all control outputs 0, ID_EX_ALUOp 0, ID_EX_Rs/Rt/Rd 0, data outputs 0.
REQ-020 Each rising edge with rst_n high, hazard low and flush low SHALL load every ID_* and IF_ID_* input into the matching ID_EX_* output; latency is exactly one cycle.
REQ-021 A load-use hazard SHALL produce exactly one stall cycle: the inserted bubble clears ID_EX_MemRead, so hazard deasserts on the following cycle while IF/ID is unchanged.
REQ-022 Back-to-back loads, each followed by a dependent instruction, SHALL each produce exactly one independent stall cycle.
REQ-023 A destination of register 0 SHALL never cause a stall.
REQ-024 stall_count SHALL increment by 1 on each rising edge where stall is high, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-025 Flush-only cycles SHALL NOT increment stall_count.

Reset
REQ-026 On a rising edge with rst_n low, all ID_EX_* outputs SHALL become 0 and stall_count SHALL become 0, regardless of flush or hazard.
REQ-027 stall SHALL be 0 in the cycle after reset, because ID_EX_MemRead is 0.
REQ-028 Reset asserted while stall is high SHALL discard the pending stall; no increment of stall_count occurs on that edge.

Verification
REQ-029 Independent case: ID_RegWrite=1, IF_ID_Rd=5, ID_RsData=0x11, no hazard -> next cycle ID_EX_RegWrite=1, ID_EX_Rd=5, ID_EX_RsData=0x11; stall=0.
REQ-030 Load-use case: a lw with ID_EX_MemRead=1 and ID_EX_Rt=8 is in EX, then an add with IF_ID_Rs=8 is in ID -> stall=1 for one cycle; bubble loaded (ID_EX_RegWrite=0, ID_EX_Rt=0); next cycle stall=0, the add enters EX; stall_count=1.
REQ-031 Register-0 case: ID_EX_MemRead=1, ID_EX_Rt=0, IF_ID_Rt=0 -> stall=0; input passes through.
REQ-032 Flush-plus-hazard case: hazard condition true and flush=1 in the same cycle -> stall=0; bubble loaded; stall_count unchanged.
REQ-033 Saturation case: CNT_W=4 with 20 forced stall events -> stall_count holds at 15.
REQ-034 Reset case: rst_n=0 mid-stall with outputs non-zero -> all outputs 0 after the edge; stall_count=0; stall=0 the next cycle.

Source files
------------

// File: rtl/id_ex_hazard_stage_if.sv
// id_ex_hazard_stage_if: ID-stage inputs and ID/EX pipeline-register outputs of the hazard stage.
interface id_ex_hazard_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic [4:0]        IF_ID_Rs, IF_ID_Rt, IF_ID_Rd;
    logic              ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst;
    logic [2:0]        ID_ALUOp;
    logic [DATA_W-1:0] ID_RsData, ID_RtData, ID_Imm;
    logic [4:0]        ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
    logic              ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_RegDst;
    logic [2:0]        ID_EX_ALUOp;
    logic [DATA_W-1:0] ID_EX_RsData, ID_EX_RtData, ID_EX_Imm;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output flush, IF_ID_Rs, IF_ID_Rt, IF_ID_Rd,
               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst,
               ID_ALUOp, ID_RsData, ID_RtData, ID_Imm,
        input  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_RegDst,
               ID_EX_ALUOp, ID_EX_RsData, ID_EX_RtData, ID_EX_Imm, stall, stall_count
    );

    modport slave (
        input  flush, IF_ID_Rs, IF_ID_Rt, IF_ID_Rd,
               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc, ID_RegDst,
               ID_ALUOp, ID_RsData, ID_RtData, ID_Imm,
        output ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
               ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_RegDst,
               ID_EX_ALUOp, ID_EX_RsData, ID_EX_RtData, ID_EX_Imm, stall, stall_count
    );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// id_ex_hazard_stage: ID/EX pipeline register with load-use stall detection, flush bubbles and a saturating stall counter.
module id_ex_hazard_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst_n,
    id_ex_hazard_stage_if.slave bus
);
    typedef struct packed {
        logic [4:0]        rs, rt, rd;
        logic              reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
        logic [2:0]        alu_op;
        logic [DATA_W-1:0] rs_data, rt_data, imm;
    } stage_t;

    stage_t           stage_q, stage_d, id_in;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hazard, stall;

    assign id_in = '{bus.IF_ID_Rs, bus.IF_ID_Rt, bus.IF_ID_Rd,
                     bus.ID_RegWrite, bus.ID_MemRead, bus.ID_MemWrite, bus.ID_MemToReg, bus.ID_ALUSrc, bus.ID_RegDst,
                     bus.ID_ALUOp, bus.ID_RsData, bus.ID_RtData, bus.ID_Imm};

    // A load in EX whose (non-zero) destination is read by the instruction in ID.
    assign hazard = stage_q.mem_read && stage_q.rt != 5'd0 &&
                    (stage_q.rt == bus.IF_ID_Rs || stage_q.rt == bus.IF_ID_Rt);
    assign stall  = hazard && !bus.flush;

    always_comb begin
        stage_d = (hazard || bus.flush) ? '0 : id_in;
        count_d = (stall && count_q != '1) ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_q <= '0;
            count_q <= '0;
        end else begin
            stage_q <= stage_d;
            count_q <= count_d;
        end
    end

    assign bus.ID_EX_Rs       = stage_q.rs;
    assign bus.ID_EX_Rt       = stage_q.rt;
    assign bus.ID_EX_Rd       = stage_q.rd;
    assign bus.ID_EX_RegWrite = stage_q.reg_write;
    assign bus.ID_EX_MemRead  = stage_q.mem_read;
    assign bus.ID_EX_MemWrite = stage_q.mem_write;
    assign bus.ID_EX_MemToReg = stage_q.mem_to_reg;
    assign bus.ID_EX_ALUSrc   = stage_q.alu_src;
    assign bus.ID_EX_RegDst   = stage_q.reg_dst;
    assign bus.ID_EX_ALUOp    = stage_q.alu_op;
    assign bus.ID_EX_RsData   = stage_q.rs_data;
    assign bus.ID_EX_RtData   = stage_q.rt_data;
    assign bus.ID_EX_Imm      = stage_q.imm;
    assign bus.stall          = stall;
    assign bus.stall_count    = count_q;
endmodule
